uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the receive-side counterpart to the existing 115200-baud transmitter on the same 100 MHz system clock.
- Samples the serial line at 16x the bit rate and recovers each byte.
- Presents each byte through a single-entry holding register with a valid/read handshake.
- Reports framing errors and overruns.
- Sits between the board RX pin and the processor's memory-mapped I/O.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVS, 16, oversampling factor (fixed at 16; other values unsupported)
ACC_W, 28, fractional tick accumulator width; must satisfy 2^ACC_W > CLK_HZ

Ports:
sys_clk_i  in  1  system clock
sys_rstn_i  in  1  reset, asynchronous, active-low
uart_rx_i  in  1  asynchronous serial input, idle high
uart_rd_i  in  1  consumer acknowledges byte; honoured only while uart_valid_o=1
uart_dat_o  out  8  received byte, stable while uart_valid_o=1
uart_valid_o  out  1  holding register full
uart_frame_err_o  out  1  one-cycle pulse: stop bit sampled low
uart_overrun_o  out  1  one-cycle pulse: byte completed while holding register full

Behaviour:
- Reset values (asynchronous on sys_rstn_i=0):
  - Synchronizer flops = 1; state = IDLE; accumulator = 0.
  - uart_dat_o=0x00, uart_valid_o=0, uart_frame_err_o=0, uart_overrun_o=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Input path: 2-flop synchronizer. All decisions use the second flop (rx_s).
- Tick generation:
  - acc += BAUD*OVS each cycle.
  - When acc >= CLK_HZ - BAUD*OVS, acc wraps by subtracting CLK_HZ and tick=1 for one cycle.
  - Default period averages 54.25 clocks.
  - acc and the sub-bit counter are cleared on the IDLE->START transition, so sampling phase is aligned to the start edge.
- Sub-bit counter: 4 bits, advances on tick, wraps 15->0. A sample is taken at count 7 (bit centre).
- FSM:
  - IDLE: rx_s==0 -> START.
  - START: at count 7, if rx_s==1 -> IDLE (glitch rejected, no flags); otherwise reset the bit index to 0 -> DATA.
  - DATA: each centre sample shifts into bit[index], LSB first; after index 7 -> STOP.
  - STOP, centre sample = 1 (good frame):
    - If uart_valid_o=0, or uart_rd_i=1 in the same cycle: load uart_dat_o, set uart_valid_o=1.
    - Otherwise drop the new byte, pulse uart_overrun_o, and keep the old byte.
    - Then -> IDLE.
  - STOP, centre sample = 0: pulse uart_frame_err_o, byte discarded, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line (break) from re-triggering starts.
- Read handshake:
  - uart_rd_i=1 with uart_valid_o=1 clears uart_valid_o on the next edge.
  - uart_rd_i while uart_valid_o=0 is ignored.
  - Simultaneous read and new-byte load: valid stays 1 with the new byte, no overrun.
- Latency: uart_valid_o rises 1 clock after the stop-bit centre tick, which is about 9.5 bit times after the start falling edge plus 2 synchronizer clocks.
- Tolerance: a correct implementation receives frames with a sender bit-rate error of up to ±3%.

Decomposition:
- Shared package uart_pkg: CLK_HZ/BAUD defaults, OVS, the 4-state enum (IDLE, START, DATA, STOP, plus BREAK -> 3-bit encoding), and frame constants (DATA_BITS=8, SAMPLE_PT=7).
- Sub-module uart_baud_tick: the fractional accumulator with a synchronous restart input. It is reusable by a future 16x-timed transmitter.

Test Plan:
- Send 0x55, then 0xA3, at exactly 115200 baud with uart_rd_i pulsed after each valid -> uart_dat_o=0x55 then 0xA3; valid asserted once per byte; no error pulses.
- 2 µs low glitch on an idle line -> returns to IDLE; no valid, no flags; a following 0x3C is received correctly.
- Send 0x81 with stop bit driven 0, line held low 20 µs, then 0x7E -> single uart_frame_err_o pulse; 0x81 not delivered; 0x7E delivered.
- Send 0x11 and 0x22 back-to-back without reading -> uart_dat_o stays 0x11; one uart_overrun_o pulse at the 0x22 stop centre.
- Repeat with uart_rd_i asserted in the same cycle the 0x22 stop sample lands -> uart_dat_o=0x22, valid=1, no overrun.
- Assert sys_rstn_i low during bit 4 of 0xF0 and release mid-frame -> outputs at reset values; the trailing bits of the frame do not produce a byte. Then send 0x0F at BAUD*1.03 and BAUD*0.97 -> 0x0F received both times.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 16x-oversampled 8N1 UART.
package uart_pkg;

  localparam int unsigned CLK_HZ_DEF = 32'd100_000_000;
  localparam int unsigned BAUD_DEF   = 32'd115_200;
  localparam int unsigned OVS        = 32'd16;
  localparam int unsigned ACC_W_DEF  = 32'd28;
  localparam int unsigned DATA_BITS  = 32'd8;
  localparam logic [3:0]  SAMPLE_PT  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional accumulator producing one-cycle ticks at BAUD*OVS on average;
// restart holds the phase at zero so the next tick lands a full period later.
module uart_baud_tick #(
  parameter int unsigned CLK_HZ = 32'd100_000_000,
  parameter int unsigned BAUD   = 32'd115_200,
  parameter int unsigned OVS    = 32'd16,
  parameter int unsigned ACC_W  = 32'd28
) (
  input  logic sys_clk_i,
  input  logic sys_rstn_i,
  input  logic restart,
  output logic tick
);
  import uart_pkg::*;

  localparam logic [ACC_W-1:0] INC    = ACC_W'(BAUD * OVS);
  localparam logic [ACC_W-1:0] WRAP   = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(CLK_HZ - BAUD * OVS);

  logic [ACC_W-1:0] acc_r;
  logic             tick_r;

  // Phase accumulator: wraps by CLK_HZ and emits a tick whenever it would overflow.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      acc_r  <= '0;
      tick_r <= 1'b0;
    end else if (restart) begin
      acc_r  <= '0;
      tick_r <= 1'b0;
    end else if (acc_r >= THRESH) begin
      acc_r  <= acc_r + INC - WRAP;
      tick_r <= 1'b1;
    end else begin
      acc_r  <= acc_r + INC;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, centre sampling, single-entry holding
// register with valid/read handshake, framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_HZ = 32'd100_000_000,
  parameter int unsigned BAUD   = 32'd115_200,
  parameter int unsigned OVS    = 32'd16,
  parameter int unsigned ACC_W  = 32'd28
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o
);
  import uart_pkg::*;

  logic [1:0] sync_r;
  logic       rx_s;
  rx_state_e  state_r;
  logic [3:0] sub_r;
  logic [2:0] idx_r;
  logic [7:0] shift_r;
  logic [7:0] dat_r;
  logic       valid_r;
  logic       ferr_r;
  logic       ovr_r;
  logic       tick_s;
  logic       restart_s;
  logic       centre_s;

  assign rx_s      = sync_r[1];
  // Holding the accumulator cleared while idle aligns sampling phase to the start edge.
  assign restart_s = (state_r == ST_IDLE);
  assign centre_s  = tick_s && (sub_r == SAMPLE_PT);

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS),
    .ACC_W  (ACC_W)
  ) u_tick (
    .sys_clk_i  (sys_clk_i),
    .sys_rstn_i (sys_rstn_i),
    .restart    (restart_s),
    .tick       (tick_s)
  );

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rx_i};
    end
  end

  // Frame FSM with sub-bit counter, shift register and registered outputs.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_r <= ST_IDLE;
      sub_r   <= 4'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      dat_r   <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
      if (uart_rd_i && valid_r) begin
        valid_r <= 1'b0;
      end
      if (tick_s) begin
        sub_r <= sub_r + 4'd1;
      end
      case (state_r)
        ST_IDLE: begin
          sub_r <= 4'd0;
          if (!rx_s) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (centre_s) begin
            if (rx_s) begin
              state_r <= ST_IDLE;
            end else begin
              idx_r   <= 3'd0;
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (centre_s) begin
            shift_r[idx_r] <= rx_s;
            if (idx_r == 3'(DATA_BITS - 32'd1)) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (centre_s) begin
            if (rx_s) begin
              // A read landing in the same cycle frees the register for the new byte.
              if (!valid_r || uart_rd_i) begin
                dat_r   <= shift_r;
                valid_r <= 1'b1;
              end else begin
                ovr_r <= 1'b1;
              end
              state_r <= ST_IDLE;
            end else begin
              ferr_r  <= 1'b1;
              state_r <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_dat_o       = dat_r;
  assign uart_valid_o     = valid_r;
  assign uart_frame_err_o = ferr_r;
  assign uart_overrun_o   = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, expected bytes queued at send
// time and popped by a monitor whenever the receiver presents a new byte.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 32'd100_000_000;
  localparam int unsigned BAUD   = 32'd1_000_000;
  localparam real         BIT_NS = 1.0e9 / BAUD;
  // Negedges from the start edge to the cycle in which the stop-bit centre tick is high:
  // 2 sync + 1 restart clocks, then tick 152 at ceil(152*6.25)=950 clocks.
  localparam int          STOP_NEG = 953;

  logic       sys_clk_i  = 1'b0;
  logic       sys_rstn_i = 1'b0;
  logic       uart_rx_i  = 1'b1;
  logic       rd_auto    = 1'b0;
  logic       rd_man     = 1'b0;
  logic       auto_rd_en = 1'b0;
  logic       uart_rd_i;
  logic [7:0] uart_dat_o;
  logic       uart_valid_o;
  logic       uart_frame_err_o;
  logic       uart_overrun_o;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic rd_q       = 1'b0;

  assign uart_rd_i = rd_auto | rd_man;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (32'd16),
    .ACC_W  (32'd28)
  ) dut (
    .sys_clk_i        (sys_clk_i),
    .sys_rstn_i       (sys_rstn_i),
    .uart_rx_i        (uart_rx_i),
    .uart_rd_i        (uart_rd_i),
    .uart_dat_o       (uart_dat_o),
    .uart_valid_o     (uart_valid_o),
    .uart_frame_err_o (uart_frame_err_o),
    .uart_overrun_o   (uart_overrun_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    @(negedge sys_clk_i);
    uart_rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      #(bit_ns);
    end
    uart_rx_i = stop_bit;
    #(bit_ns);
    if (stop_bit) uart_rx_i = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge sys_clk_i);
    check(name, exp_q.size(), 0);
  endtask

  // Read value as seen by the DUT at each active edge.
  initial forever begin
    @(posedge sys_clk_i);
    rd_q = uart_rd_i;
  end

  // Auto-reader: one-cycle read pulse per presented byte when enabled.
  initial forever begin
    @(negedge sys_clk_i);
    rd_auto = auto_rd_en && uart_valid_o && !rd_auto;
  end

  // Monitor: counts error pulses and scores every newly presented byte.
  initial forever begin
    @(negedge sys_clk_i);
    if (uart_frame_err_o === 1'b1) fe_cnt++;
    if (uart_overrun_o === 1'b1) ov_cnt++;
    if (uart_valid_o === 1'b1 && (!prev_valid || rd_q)) begin
      if (exp_q.size() == 0) check("byte_expected", 32'(uart_dat_o) | 32'h100, 32'h0);
      else                   check("rx_byte", uart_dat_o, exp_q.pop_front());
    end
    prev_valid = uart_valid_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_dat", uart_dat_o, 8'h00);
    check("rst_valid", uart_valid_o, 1'b0);
    check("rst_ferr", uart_frame_err_o, 1'b0);
    check("rst_ovr", uart_overrun_o, 1'b0);
    #30 sys_rstn_i = 1'b1;
    auto_rd_en = 1'b1;
    #(2.0 * BIT_NS);

    // Two clean frames, each read back.
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT_NS);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, BIT_NS);
    wait_drain("t1_drain");
    #(BIT_NS);
    check("t1_valid_cleared", uart_valid_o, 1'b0);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);

    // Short low glitch is rejected, next frame still received.
    @(negedge sys_clk_i);
    uart_rx_i = 1'b0;
    #230;
    uart_rx_i = 1'b1;
    #(3.0 * BIT_NS);
    check("t2_glitch_fe", fe_cnt, 0);
    check("t2_glitch_valid", uart_valid_o, 1'b0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BIT_NS);
    wait_drain("t2_drain");

    // Bad stop bit followed by a held-low line, then a good frame.
    send_byte(8'h81, 1'b0, BIT_NS);
    #20_000;
    uart_rx_i = 1'b1;
    #(2.0 * BIT_NS);
    check("t3_fe", fe_cnt, 1);
    check("t3_valid", uart_valid_o, 1'b0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, BIT_NS);
    wait_drain("t3_drain");
    check("t3_fe_after", fe_cnt, 1);

    // Back-to-back without reading: second byte overruns.
    auto_rd_en = 1'b0;
    #(BIT_NS);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    #(BIT_NS);
    check("t4_ov", ov_cnt, 1);
    check("t4_dat", uart_dat_o, 8'h11);
    check("t4_valid", uart_valid_o, 1'b1);
    @(negedge sys_clk_i); rd_man = 1'b1;
    @(negedge sys_clk_i); rd_man = 1'b0;
    @(negedge sys_clk_i);
    check("t4_read_clears", uart_valid_o, 1'b0);
    wait_drain("t4_drain");

    // Read coincident with the second byte's stop sample: no overrun.
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, BIT_NS);
    exp_q.push_back(8'h22);
    #2;
    fork
      send_byte(8'h22, 1'b1, BIT_NS);
      begin
        @(negedge sys_clk_i);
        repeat (STOP_NEG) @(negedge sys_clk_i);
        rd_man = 1'b1;
        @(negedge sys_clk_i);
        rd_man = 1'b0;
      end
    join
    #(BIT_NS);
    check("t5_ov", ov_cnt, 1);
    check("t5_dat", uart_dat_o, 8'h22);
    check("t5_valid", uart_valid_o, 1'b1);
    wait_drain("t5_drain");

    // Reset during bit 4 of 0xF0 abandons the frame and clears the register.
    fork
      send_byte(8'hF0, 1'b1, BIT_NS);
      begin
        #(5.5 * BIT_NS);
        sys_rstn_i = 1'b0;
        #1;
        check("t6_rst_dat", uart_dat_o, 8'h00);
        check("t6_rst_valid", uart_valid_o, 1'b0);
        check("t6_rst_ferr", uart_frame_err_o, 1'b0);
        check("t6_rst_ovr", uart_overrun_o, 1'b0);
        #300;
        sys_rstn_i = 1'b1;
      end
    join
    #(2.0 * BIT_NS);
    check("t6_no_byte", uart_valid_o, 1'b0);
    check("t6_fe", fe_cnt, 1);
    check("t6_ov", ov_cnt, 1);

    // Sender rate offsets of +3% and -3%.
    auto_rd_en = 1'b1;
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, 1.0e9 / (real'(BAUD) * 1.03));
    #(2.0 * BIT_NS);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, 1.0e9 / (real'(BAUD) * 0.97));
    wait_drain("t7_drain");
    #(BIT_NS);
    check("t7_fe", fe_cnt, 1);
    check("t7_ov", ov_cnt, 1);
    check("t7_valid_cleared", uart_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
